// File: rtl/psum_pkg.sv
// Shared types and default widths for the partial-sum pass scheduler.
package psum_pkg;

  localparam int unsigned LANE_WIDTH     = 8;
  localparam int unsigned LANES          = 4;
  localparam int unsigned DATA_WIDTH_DEF = LANES * LANE_WIDTH;
  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned CNT_WIDTH_DEF  = 16;

  // Scheduler phases: who owns the buffer port and what it is doing.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; head word is visible on dout while not empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  // Storage, pointers and occupancy; reset discards all contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A push into a full FIFO would silently drop a word.
  assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop))
    else $error("sync_fifo: push while full");

endmodule

// File: rtl/psum_pass_sched.sv
// Owns the partial-sum buffer port: lends it to the accumulator for npass
// passes, then drains and zero-clears the npix accumulated words.
module psum_pass_sched
  import psum_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int unsigned MEM_DELAY  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_npass,
  input  logic [CNT_WIDTH-1:0]  cfg_npix,
  output logic                  busy,
  output logic                  done,
  output logic                  acc_first,
  output logic                  acc_en,
  input  logic                  psum_knx_end,
  input  logic [ADDR_WIDTH-1:0] acc_radd,
  input  logic                  acc_rden,
  input  logic [ADDR_WIDTH-1:0] acc_wadd,
  input  logic                  acc_wren,
  input  logic [DATA_WIDTH-1:0] acc_idat,
  output logic [ADDR_WIDTH-1:0] mem_radd,
  output logic                  mem_rden,
  output logic [ADDR_WIDTH-1:0] mem_wadd,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_idat,
  input  logic [DATA_WIDTH-1:0] mem_odat,
  input  logic                  mem_oval,
  output logic [DATA_WIDTH-1:0] out_dat,
  output logic                  out_vld,
  input  logic                  out_rdy
);

  localparam int unsigned FA  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = FA + 1;
  localparam int unsigned TMO = MEM_DELAY + 3;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  npass_q, npass_d;
  logic [CNT_WIDTH-1:0]  npix_q, npix_d;
  logic [CNT_WIDTH-1:0]  pass_cnt_q, pass_cnt_d;
  logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_WIDTH-1:0]  tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  pop_cnt_q, pop_cnt_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic                  clr_vld_q, clr_vld_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  acc_en_q, acc_en_d;
  logic                  acc_first_q, acc_first_d;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CW:0]           occ_sum;
  logic                  issue;
  logic                  push;
  logic                  pop;

  // Reads are only issued while every in-flight word already has a FIFO slot.
  assign occ_sum = (CW+1)'(fifo_count) + (CW+1)'(outst_q);
  assign issue   = (state_q == ST_DRAIN) && (rd_ptr_q < npix_q) && !fifo_full &&
                   (occ_sum < (CW+1)'(FIFO_DEPTH));
  assign push    = (state_q == ST_DRAIN) && mem_oval;
  assign pop     = !fifo_empty && out_rdy;

  assign out_vld   = !fifo_empty;
  assign busy      = busy_q;
  assign done      = done_q;
  assign acc_en    = acc_en_q;
  assign acc_first = acc_first_q;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (mem_odat),
    .dout  (out_dat),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // State, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      npass_q     <= '0;
      npix_q      <= '0;
      pass_cnt_q  <= '0;
      wr_cnt_q    <= '0;
      tmo_q       <= '0;
      rd_ptr_q    <= '0;
      pop_cnt_q   <= '0;
      outst_q     <= '0;
      clr_vld_q   <= 1'b0;
      clr_addr_q  <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      acc_en_q    <= 1'b0;
      acc_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      npass_q     <= npass_d;
      npix_q      <= npix_d;
      pass_cnt_q  <= pass_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      tmo_q       <= tmo_d;
      rd_ptr_q    <= rd_ptr_d;
      pop_cnt_q   <= pop_cnt_d;
      outst_q     <= outst_d;
      clr_vld_q   <= clr_vld_d;
      clr_addr_q  <= clr_addr_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      acc_en_q    <= acc_en_d;
      acc_first_q <= acc_first_d;
    end
  end

  // Next-state: pass sequencing, flush exit and drain bookkeeping.
  always_comb begin
    state_d    = state_q;
    npass_d    = npass_q;
    npix_d     = npix_q;
    pass_cnt_d = pass_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    tmo_d      = tmo_q;
    rd_ptr_d   = rd_ptr_q;
    pop_cnt_d  = pop_cnt_q;
    outst_d    = outst_q;
    clr_vld_d  = 1'b0;
    clr_addr_d = clr_addr_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_ACCUM;
          npass_d    = (cfg_npass == '0) ? CNT_WIDTH'(1) : cfg_npass;
          npix_d     = (cfg_npix == '0) ? CNT_WIDTH'(1) : cfg_npix;
          pass_cnt_d = '0;
          wr_cnt_d   = '0;
          tmo_d      = '0;
          rd_ptr_d   = '0;
          pop_cnt_d  = '0;
          outst_d    = '0;
        end
      end
      ST_ACCUM: begin
        if (acc_wren) wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
        if (psum_knx_end) begin
          if (pass_cnt_q == npass_q - CNT_WIDTH'(1)) begin
            state_d = ST_FLUSH;
            tmo_d   = '0;
          end else begin
            pass_cnt_d = pass_cnt_q + CNT_WIDTH'(1);
            wr_cnt_d   = '0;
          end
        end
      end
      ST_FLUSH: begin
        if (acc_wren) begin
          wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
          tmo_d    = '0;
        end else begin
          tmo_d = tmo_q + CNT_WIDTH'(1);
        end
        // Leave once the last pass has fully landed, or the writer went quiet.
        if ((wr_cnt_q >= npix_q) || (!acc_wren && (tmo_q == CNT_WIDTH'(TMO - 1))))
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (issue) begin
          rd_ptr_d   = rd_ptr_q + CNT_WIDTH'(1);
          clr_vld_d  = 1'b1;
          clr_addr_d = ADDR_WIDTH'(rd_ptr_q);
        end
        outst_d = outst_q + CW'(issue) - CW'(push);
        if (pop) begin
          pop_cnt_d = pop_cnt_q + CNT_WIDTH'(1);
          if (pop_cnt_q == npix_q - CNT_WIDTH'(1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d != ST_IDLE);
    acc_en_d    = (state_d == ST_ACCUM);
    acc_first_d = (state_d == ST_ACCUM) && (pass_cnt_d == '0);
  end

  // Buffer port mux: accumulator while accumulating/flushing, drain engine after.
  always_comb begin
    mem_radd = '0;
    mem_rden = 1'b0;
    mem_wadd = '0;
    mem_wren = 1'b0;
    mem_idat = '0;
    case (state_q)
      ST_ACCUM, ST_FLUSH: begin
        mem_radd = acc_radd;
        mem_rden = acc_rden;
        mem_wadd = acc_wadd;
        mem_wren = acc_wren;
        mem_idat = acc_idat;
      end
      ST_DRAIN: begin
        mem_radd = ADDR_WIDTH'(rd_ptr_q);
        mem_rden = issue;
        mem_wadd = clr_addr_q;
        mem_wren = clr_vld_q;
        mem_idat = '0;
      end
      default: ;
    endcase
  end

endmodule
